vx_commit_assembler: RTL and testbench

Receive-side counterpart of the partial-bandwidth commit stream that execute units emit through their gather stage. One instance per issue slot. It accepts commit beats carrying NUM_LANES lanes plus a packet id (pid), sop and eop. It reassembles them into a single full-warp NUM_THREADS-wide writeback packet for the writeback/scoreboard stage.

---
 rtl/vx_commit_assembler_if.sv | 52 +++++
 rtl/vx_commit_assembler.sv | 123 ++++++++++++
 tb/tb_vx_commit_assembler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_commit_assembler_if.sv
// Commit-beat input stream and assembled writeback packet output of vx_commit_assembler.
// The master modport is the producer/consumer side; slave is the assembler itself.
interface vx_commit_assembler_if #(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned NUM_THREADS = 16,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned UUID_W      = 44,
  parameter int unsigned NW_W        = 2,
  parameter int unsigned PC_W        = 30,
  parameter int unsigned NR_W        = 6
);
  localparam int unsigned NUM_GROUPS = NUM_THREADS / NUM_LANES;
  localparam int unsigned PID_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [UUID_W-1:0]           in_uuid;
  logic [NW_W-1:0]             in_wid;
  logic [NUM_LANES-1:0]        in_tmask;
  logic [PC_W-1:0]             in_pc;
  logic [NR_W-1:0]             in_rd;
  logic                        in_wb;
  logic [NUM_LANES*XLEN-1:0]   in_data;
  logic [PID_W-1:0]            in_pid;
  logic                        in_sop;
  logic                        in_eop;

  logic                        out_valid;
  logic                        out_ready;
  logic [UUID_W-1:0]           out_uuid;
  logic [NW_W-1:0]             out_wid;
  logic [NUM_THREADS-1:0]      out_tmask;
  logic [PC_W-1:0]             out_pc;
  logic [NR_W-1:0]             out_rd;
  logic                        out_wb;
  logic [NUM_THREADS*XLEN-1:0] out_data;
  logic                        proto_err;

  modport master (
    output in_valid, in_uuid, in_wid, in_tmask, in_pc, in_rd, in_wb, in_data, in_pid, in_sop,
           in_eop, out_ready,
    input  in_ready, out_valid, out_uuid, out_wid, out_tmask, out_pc, out_rd, out_wb, out_data,
           proto_err
  );

  modport slave (
    input  in_valid, in_uuid, in_wid, in_tmask, in_pc, in_rd, in_wb, in_data, in_pid, in_sop,
           in_eop, out_ready,
    output in_ready, out_valid, out_uuid, out_wid, out_tmask, out_pc, out_rd, out_wb, out_data,
           proto_err
  );
endinterface

// File: rtl/vx_commit_assembler.sv
// Reassembles NUM_LANES-wide commit beats (sop..eop, indexed by pid) into one full-warp
// writeback packet. Outputs come straight from the assembly buffer registers.
module vx_commit_assembler #(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned NUM_THREADS = 16,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned UUID_W      = 44,
  parameter int unsigned NW_W        = 2,
  parameter int unsigned PC_W        = 30,
  parameter int unsigned NR_W        = 6
) (
  input logic                  clk,
  input logic                  reset,
  vx_commit_assembler_if.slave bus
);
  localparam int unsigned NUM_GROUPS = NUM_THREADS / NUM_LANES;
  localparam int unsigned PID_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  typedef enum logic [1:0] {StIdle, StAccum, StFull} state_e;

  state_e                      r_state,   w_state_nxt;
  logic [NUM_THREADS-1:0]      r_tmask,   w_tmask_nxt;
  logic [NUM_THREADS*XLEN-1:0] r_data,    w_data_nxt;
  logic [UUID_W-1:0]           r_uuid,    w_uuid_nxt;
  logic [NW_W-1:0]             r_wid,     w_wid_nxt;
  logic [PC_W-1:0]             r_pc,      w_pc_nxt;
  logic [NR_W-1:0]             r_rd,      w_rd_nxt;
  logic                        r_wb,      w_wb_nxt;
  logic                        r_perr,    w_perr_nxt;

  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic w_write;

  assign w_in_ready = (r_state != StFull) || bus.out_ready;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = (r_state == StFull) && bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_tmask_nxt = r_tmask;
    w_data_nxt  = r_data;
    w_uuid_nxt  = r_uuid;
    w_wid_nxt   = r_wid;
    w_pc_nxt    = r_pc;
    w_rd_nxt    = r_rd;
    w_wb_nxt    = r_wb;
    w_perr_nxt  = 1'b0;
    w_write     = 1'b0;

    if (w_out_fire) w_state_nxt = StIdle;

    if (w_in_fire) begin
      if (bus.in_sop) begin
        // A sop while accumulating abandons the partial packet.
        w_perr_nxt  = (r_state == StAccum);
        w_tmask_nxt = '0;
        w_data_nxt  = '0;
        w_uuid_nxt  = bus.in_uuid;
        w_wid_nxt   = bus.in_wid;
        w_pc_nxt    = bus.in_pc;
        w_rd_nxt    = bus.in_rd;
        w_wb_nxt    = bus.in_wb;
        w_write     = 1'b1;
        w_state_nxt = bus.in_eop ? StFull : StAccum;
      end else if (r_state == StAccum) begin
        w_write = 1'b1;
        if (bus.in_eop) w_state_nxt = StFull;
      end else begin
        w_perr_nxt = 1'b1;
      end
    end

    // Whole pid slot is rewritten so a repeated pid simply overwrites; masked lanes read 0.
    if (w_write) begin
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
        if (bus.in_pid == PID_W'(g)) begin
          for (int unsigned i = 0; i < NUM_LANES; i++) begin
            w_tmask_nxt[g*NUM_LANES+i] = bus.in_tmask[i];
            w_data_nxt[(g*NUM_LANES+i)*XLEN +: XLEN] =
                bus.in_tmask[i] ? bus.in_data[i*XLEN +: XLEN] : '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_tmask <= '0;
      r_data  <= '0;
      r_uuid  <= '0;
      r_wid   <= '0;
      r_pc    <= '0;
      r_rd    <= '0;
      r_wb    <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmask <= w_tmask_nxt;
      r_data  <= w_data_nxt;
      r_uuid  <= w_uuid_nxt;
      r_wid   <= w_wid_nxt;
      r_pc    <= w_pc_nxt;
      r_rd    <= w_rd_nxt;
      r_wb    <= w_wb_nxt;
      r_perr  <= w_perr_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == StFull);
  assign bus.out_uuid  = r_uuid;
  assign bus.out_wid   = r_wid;
  assign bus.out_tmask = r_tmask;
  assign bus.out_pc    = r_pc;
  assign bus.out_rd    = r_rd;
  assign bus.out_wb    = r_wb;
  assign bus.out_data  = r_data;
  assign bus.proto_err = r_perr;
endmodule

// File: tb/tb_vx_commit_assembler.sv
// Scoreboard bench for vx_commit_assembler: directed packets push expected results into a
// queue, and a negedge monitor pops and compares every transferred output packet.
module tb_vx_commit_assembler;
  localparam int unsigned L = 4;
  localparam int unsigned T = 16;
  localparam int unsigned X = 32;

  typedef struct {
    logic [43:0]    uuid;
    logic [1:0]     wid;
    logic [29:0]    pc;
    logic [5:0]     rd;
    logic           wb;
    logic [T-1:0]   tmask;
    logic [T*X-1:0] data;
  } pkt_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   pkt_cnt = 0;
  int   perr_cnt = 0;
  pkt_t exp_q[$];

  vx_commit_assembler_if #(
    .NUM_LANES(L), .NUM_THREADS(T), .XLEN(X), .UUID_W(44), .NW_W(2), .PC_W(30), .NR_W(6)
  ) bus ();

  vx_commit_assembler #(
    .NUM_LANES(L), .NUM_THREADS(T), .XLEN(X), .UUID_W(44), .NW_W(2), .PC_W(30), .NR_W(6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [T*X-1:0] act, input logic [T*X-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Header fields are a fixed function of uuid so each packet's header is distinct.
  function automatic logic [1:0]  h_wid(input logic [43:0] u); return u[1:0];              endfunction
  function automatic logic [29:0] h_pc (input logic [43:0] u); return u[29:0] ^ 30'h1234;   endfunction
  function automatic logic [5:0]  h_rd (input logic [43:0] u); return u[5:0] + 6'd1;       endfunction
  function automatic logic        h_wb (input logic [43:0] u); return ~u[0];               endfunction

  // Lane i of beat pid carries 0x100 + 16*pid + i.
  function automatic logic [L*X-1:0] beat_data(input int pid);
    logic [L*X-1:0] d;
    for (int i = 0; i < L; i++) d[i*X +: X] = 32'h100 + 32'(16*pid + i);
    return d;
  endfunction

  // Thread t = 4*pid + i, so its value is 0x100 + 16*(t/4) + t%4 when received, else 0.
  function automatic pkt_t mk_pkt(input logic [43:0] u, input logic [T-1:0] tm);
    pkt_t p;
    p.uuid = u; p.wid = h_wid(u); p.pc = h_pc(u); p.rd = h_rd(u); p.wb = h_wb(u);
    p.tmask = tm;
    p.data  = '0;
    for (int t = 0; t < T; t++)
      if (tm[t]) p.data[t*X +: X] = 32'h100 + 32'(16*(t/4) + (t%4));
    return p;
  endfunction

  task automatic drive(input logic [43:0] u, input int pid, input logic sop, input logic eop,
                       input logic [L-1:0] tm);
    logic [43:0] hu;
    hu = sop ? u : (u ^ 44'hABC);
    bus.in_valid = 1'b1;
    bus.in_uuid  = hu;
    bus.in_wid   = h_wid(hu);
    bus.in_pc    = h_pc(hu);
    bus.in_rd    = h_rd(hu);
    bus.in_wb    = h_wb(hu);
    bus.in_pid   = 2'(pid);
    bus.in_tmask = tm;
    bus.in_data  = beat_data(pid);
    bus.in_sop   = sop;
    bus.in_eop   = eop;
  endtask

  task automatic wait_accept(input string name);
    logic acc;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    chk({name, "_accept"}, acc, 1'b1);
  endtask

  task automatic send(input logic [43:0] u, input int pid, input logic sop, input logic eop,
                      input logic [L-1:0] tm);
    drive(u, pid, sop, eop, tm);
    wait_accept("send");
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (bus.proto_err) perr_cnt++;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got packet uuid %0h expected none", bus.out_uuid);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        chk("pkt_uuid",  bus.out_uuid,  e.uuid);
        chk("pkt_wid",   bus.out_wid,   e.wid);
        chk("pkt_pc",    bus.out_pc,    e.pc);
        chk("pkt_rd",    bus.out_rd,    e.rd);
        chk("pkt_wb",    bus.out_wb,    e.wb);
        chk("pkt_tmask", bus.out_tmask, e.tmask);
        chk("pkt_data",  bus.out_data,  e.data);
      end
      pkt_cnt++;
    end
  end

  initial begin
    int   p0;
    int   e0;
    pkt_t bp;

    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_uuid = '0; bus.in_wid = '0; bus.in_pc = '0; bus.in_rd = '0;
    bus.in_wb = 1'b0; bus.in_pid = '0; bus.in_tmask = '0; bus.in_data = '0;
    bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.out_ready = 1'b1;

    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_proto_err", bus.proto_err, 1'b0);
    chk("rst_tmask",     bus.out_tmask, '0);
    chk("rst_data",      bus.out_data,  '0);
    chk("rst_uuid",      bus.out_uuid,  '0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk("rst_in_ready",  bus.in_ready,  1'b1);

    // Full four-beat packet; out_valid must be up right after the eop edge.
    exp_q.push_back(mk_pkt(44'h11, 16'hFFFF));
    send(44'h11, 0, 1'b1, 1'b0, 4'hF);
    send(44'h11, 1, 1'b0, 1'b0, 4'hF);
    send(44'h11, 2, 1'b0, 1'b0, 4'hF);
    send(44'h11, 3, 1'b0, 1'b1, 4'hF);
    chk("full_latency", bus.out_valid, 1'b1);
    idle(2);

    // Sparse packet: pid1 and pid3 skipped.
    exp_q.push_back(mk_pkt(44'h22, 16'h030F));
    send(44'h22, 0, 1'b1, 1'b0, 4'hF);
    send(44'h22, 2, 1'b0, 1'b1, 4'h3);
    idle(2);

    // Backpressure with the next sop already waiting.
    bus.out_ready = 1'b0;
    bp = mk_pkt(44'h33, 16'hFFFF);
    exp_q.push_back(bp);
    send(44'h33, 0, 1'b1, 1'b0, 4'hF);
    send(44'h33, 1, 1'b0, 1'b0, 4'hF);
    send(44'h33, 2, 1'b0, 1'b0, 4'hF);
    send(44'h33, 3, 1'b0, 1'b1, 4'hF);
    drive(44'h44, 0, 1'b1, 1'b0, 4'hF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready",  bus.in_ready,  1'b0);
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_uuid",      bus.out_uuid,  bp.uuid);
      chk("bp_data",      bus.out_data,  bp.data);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_accept("bp_release");
    chk("bp_new_accum", bus.out_valid, 1'b0);
    exp_q.push_back(mk_pkt(44'h44, 16'hFFFF));
    send(44'h44, 1, 1'b0, 1'b0, 4'hF);
    send(44'h44, 2, 1'b0, 1'b0, 4'hF);
    send(44'h44, 3, 1'b0, 1'b1, 4'hF);
    idle(2);

    // Back-to-back single-beat packets.
    p0 = pkt_cnt;
    e0 = perr_cnt;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(mk_pkt(44'h50 + 44'(k), 16'h000F));
      send(44'h50 + 44'(k), 0, 1'b1, 1'b1, 4'hF);
      chk("b2b_valid", bus.out_valid, 1'b1);
      chk("b2b_uuid",  bus.out_uuid,  44'h50 + 44'(k));
    end
    idle(3);
    chk("b2b_count", 32'(pkt_cnt - p0), 32'd8);
    chk("b2b_perr",  32'(perr_cnt - e0), 32'd0);

    // sop interrupting a partial packet.
    e0 = perr_cnt;
    exp_q.push_back(mk_pkt(44'h07, 16'h00F0));
    send(44'h05, 0, 1'b1, 1'b0, 4'hF);
    send(44'h07, 1, 1'b1, 1'b1, 4'hF);
    idle(3);
    chk("resop_perr", 32'(perr_cnt - e0), 32'd1);

    // Non-sop beat while idle is dropped.
    e0 = perr_cnt;
    p0 = pkt_cnt;
    send(44'h66, 2, 1'b0, 1'b1, 4'hF);
    idle(3);
    chk("idle_drop_perr",  32'(perr_cnt - e0), 32'd1);
    chk("idle_drop_count", 32'(pkt_cnt - p0),  32'd0);
    chk("idle_drop_valid", bus.out_valid,      1'b0);

    // Reset in the middle of a packet.
    send(44'h77, 0, 1'b1, 1'b0, 4'hF);
    send(44'h77, 1, 1'b0, 1'b0, 4'hF);
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_tmask", bus.out_tmask, '0);
    #10 reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    exp_q.push_back(mk_pkt(44'h78, 16'h1111));
    send(44'h78, 0, 1'b1, 1'b0, 4'h1);
    send(44'h78, 1, 1'b0, 1'b0, 4'h1);
    send(44'h78, 2, 1'b0, 1'b0, 4'h1);
    send(44'h78, 3, 1'b0, 1'b1, 4'h1);
    idle(2);

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
